conv_interleaver: RTL and testbench
===================================

Name: conv_interleaver

Overview:
- Parametrised Forney convolutional interleaver; successor to the fixed single-depth 8-bit delay lines in the interleaver path.
- Holds BRANCHES branches; branch j delays its own symbols by j*M writes to that branch. Branch 0 has no storage.
- A commutator steps through the branches, one step per accepted symbol.
- Sits between the RS encoder output and the modulator byte stream. Input is valid-gated, so gaps in the stream are allowed.

Parameters:
- WIDTH, 8, symbol width in bits
- BRANCHES, 12, number of commutator branches (>=2)
- M, 17, delay unit; branch j holds j*M symbols (>=1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  symbol present on in_data this cycle
- in_data  in  WIDTH  input symbol
- in_sync  in  1  sync marker qualified by in_valid; used only with SYNC_ALIGN_EN
- out_valid  out  1  out_data/out_branch valid
- out_data  out  WIDTH  interleaved symbol
- out_branch  out  $clog2(BRANCHES)  branch the output symbol came from
- primed  out  1  every branch now outputs real data; sticky until reset

Behaviour:
- Reset (reset=0, asynchronous):
  - commutator = 0; all branch pointers and fill counters = 0.
  - out_valid = 0, out_data = 0, out_branch = 0, primed = 0.
  - Storage contents need not clear; fill counters guarantee zero output.
- Accept rule: a symbol is accepted when in_valid=1 at a rising clk edge. No backpressure; every valid symbol is accepted.
- On each accepted symbol:
  - It is written to branch b = commutator.
  - Commutator then advances b -> b+1, wrapping BRANCHES-1 -> 0.
  - in_valid=0 cycles leave all state unchanged.
- Output timing: registered, latency 1 cycle.
  - out_valid(t+1) = in_valid(t).
  - out_branch = b.
  - When out_valid=0, out_data and out_branch hold their last values.
- out_data by branch:
  - b = 0: out_data = the in_data just accepted.
  - b > 0, writes to branch b before this one < b*M: out_data = 0 (fill value).
  - Otherwise: out_data = the symbol written to branch b exactly b*M branch-b writes earlier.
- Per-branch storage:
  - Circular buffer of depth b*M; read and write share one pointer, wrapping b*M-1 -> 0.
  - Fill counter saturates at b*M.
- Simultaneous read/write on the same branch: read returns the old symbol and the write replaces it (read-before-write).
- primed:
  - Rises with the out_valid of the first branch BRANCHES-1 symbol that is not fill.
  - That is the accepted symbol number BRANCHES*(BRANCHES-1)*M + BRANCHES, 1-based; 2256 at defaults.
  - Stays 1 until reset.
- Total end-to-end delay through interleaver plus matching deinterleaver = (BRANCHES-1)*M*BRANCHES symbols. This is informative only; not checked here.
- Reset asserted mid-stream: all state returns to reset values immediately. The next accepted symbol goes to branch 0 with all branches refilling from empty.

Optional Feature:
- Macro SYNC_ALIGN_EN.
- Defined: an accepted symbol with in_sync=1 is forced to branch 0, whatever the commutator value. The commutator then continues from 1. Fill counters and buffers of the skipped branches are not disturbed.
- Not defined: in_sync is ignored and the commutator free-runs.
- Port list is identical in both builds.

Test Plan:
1. Reset, then accept 0x47 as the first symbol -> next cycle out_valid=1, out_data=0x47, out_branch=0.
2. Continuous in_valid, in_data = index mod 256 starting at 0 (defaults):
   - index 1 -> out_data=0x00, out_branch=1 (fill).
   - index 205 (=1+12*17) -> out_data=0x01, out_branch=1.
   - index 13 -> out_data=0x00.
3. Same stream as test 2 with in_valid toggling 1,0,1,0 -> out_data sequence over valid outputs identical to test 2; out_valid follows in_valid delayed 1 cycle.
4. Continuous stream -> primed=0 through accepted symbol 2255; primed=1 with symbol 2256's out_valid; stays 1 thereafter.
5. SYNC_ALIGN_EN defined, in_sync=1 on accepted symbol index 5 (commutator=5):
   - that symbol outputs with out_branch=0 and its own data.
   - next symbol gets out_branch=1.
   - Without the macro, the same stimulus gives out_branch=5.
6. Reset pulsed low mid-stream after symbol 1000:
   - out_valid, out_data and primed go to 0 without waiting for a clock edge.
   - After release, rerunning test 2's stream reproduces test 2's outputs exactly.

Source files
------------

// File: rtl/conv_interleaver.sv
// conv_interleaver: parametrised Forney convolutional interleaver.
// Branch j delays its symbols by j*M writes to that branch; branch 0 is a
// straight wire. All branch buffers share one flat symbol memory, branch j
// occupying a window of j*M entries starting at M*j*(j-1)/2.
// Optional build macro SYNC_ALIGN_EN: an accepted symbol with in_sync=1 is
// forced onto branch 0 and the commutator resumes from branch 1.
module conv_interleaver #(
  parameter int WIDTH    = 8,
  parameter int BRANCHES = 12,
  parameter int M        = 17
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_sync,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic [$clog2(BRANCHES)-1:0] out_branch,
  output logic                        primed
);

  localparam int BW    = $clog2(BRANCHES);
  localparam int MAXD  = (BRANCHES - 1) * M;
  localparam int PW    = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam int FW    = $clog2(MAXD + 1);
  localparam int TOTAL = (M * BRANCHES * (BRANCHES - 1)) / 2;
  localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  logic [BW-1:0]    comm_q;
  logic [BW-1:0]    comm_d;
  logic [PW-1:0]    ptr_q  [BRANCHES];
  logic [FW-1:0]    fill_q [BRANCHES];
  logic [WIDTH-1:0] mem    [TOTAL];

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [BW-1:0]    out_branch_q;
  logic             primed_q;

  logic [BW-1:0]    b_s;
  logic [FW-1:0]    depth_s;
  logic [AW-1:0]    base_s;
  logic [AW-1:0]    addr_s;
  logic             full_s;
  logic [PW-1:0]    ptr_nxt_s;
  logic [WIDTH-1:0] rd_s;

  // Branch selection, buffer addressing and fill status for the current symbol.
  always_comb begin
`ifdef SYNC_ALIGN_EN
    if (in_sync) begin
      b_s = '0;
    end else begin
      b_s = comm_q;
    end
`else
    b_s = comm_q;
`endif
    comm_d    = (b_s == BW'(BRANCHES - 1)) ? '0 : b_s + BW'(1);
    depth_s   = FW'(M * int'(b_s));
    base_s    = AW'((M * int'(b_s) * (int'(b_s) - 1)) / 2);
    addr_s    = base_s + AW'(ptr_q[b_s]);
    full_s    = (fill_q[b_s] == depth_s);
    ptr_nxt_s = (FW'(ptr_q[b_s]) == depth_s - FW'(1)) ? '0 : ptr_q[b_s] + PW'(1);
    rd_s      = mem[addr_s];
  end

  // Symbol storage: no reset needed, fill counters mask stale contents.
  always_ff @(posedge clk) begin
    if (in_valid && (b_s != '0)) begin
      mem[addr_s] <= in_data;
    end
  end

  // Commutator, per-branch pointers/fill counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      comm_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_branch_q <= '0;
      primed_q     <= 1'b0;
      for (int j = 0; j < BRANCHES; j++) begin
        ptr_q[j]  <= '0;
        fill_q[j] <= '0;
      end
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        comm_q       <= comm_d;
        out_branch_q <= b_s;
        if (b_s == '0) begin
          out_data_q <= in_data;
        end else begin
          // Read-before-write: the old entry leaves as the new one lands.
          out_data_q <= full_s ? rd_s : '0;
          ptr_q[b_s] <= ptr_nxt_s;
          if (!full_s) begin
            fill_q[b_s] <= fill_q[b_s] + FW'(1);
          end
          if ((b_s == BW'(BRANCHES - 1)) && full_s) begin
            primed_q <= 1'b1;
          end
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_branch = out_branch_q;
  assign primed     = primed_q;

endmodule

// File: tb/tb_conv_interleaver.sv
// Scoreboard bench for conv_interleaver at default parameters.
module tb_conv_interleaver;

  localparam int WIDTH   = 8;
  localparam int BR      = 12;
  localparam int M       = 17;
  localparam int BW      = $clog2(BR);
  localparam int PRIME_N = BR * (BR - 1) * M + BR;   // 2256
  localparam int CAP     = 2400;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_sync = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [BW-1:0]    out_branch;
  logic             primed;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [BW-1:0]    b;
    logic             p;
  } exp_t;

  exp_t             sb[$];
  int               n_cmp = 0;
  int               n_err = 0;
  int               sent = 0;
  logic             exp_ov;
  logic [WIDTH-1:0] last_d = '0;
  int               cap_idx = 0;
  logic [WIDTH-1:0] cap_d [CAP];
  logic [BW-1:0]    cap_b [CAP];

  conv_interleaver #(.WIDTH(WIDTH), .BRANCHES(BR), .M(M)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_sync(in_sync), .out_valid(out_valid), .out_data(out_data),
    .out_branch(out_branch), .primed(primed)
  );

  always #5 clk = ~clk;

  // out_valid must follow in_valid one cycle later.
  always @(posedge clk or negedge reset) begin
    if (!reset) exp_ov <= 1'b0;
    else        exp_ov <= in_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Analytic expected output for stream index i (data = i mod 256) from reset.
  function automatic logic [WIDTH-1:0] exp_data(input int i);
    int b = i % BR;
    int k = i / BR;
    if (b == 0) return WIDTH'(i % 256);
    if (k < b * M) return '0;
    return WIDTH'((i - BR * b * M) % 256);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        last_d  = '0;
        cap_idx = 0;
      end else begin
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        if (out_valid) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: got data %0h branch %0d expected none", out_data, out_branch);
          end else begin
            e = sb.pop_front();
            chk("out_data", 32'(out_data), 32'(e.d));
            chk("out_branch", 32'(out_branch), 32'(e.b));
            chk("primed", 32'(primed), 32'(e.p));
          end
          if (cap_idx < CAP) begin
            cap_d[cap_idx] = out_data;
            cap_b[cap_idx] = out_branch;
          end
          cap_idx++;
          last_d = out_data;
        end else begin
          chk("hold_data", 32'(out_data), 32'(last_d));
        end
      end
    end
  end

  task automatic send(input int val, input logic sync, input logic [WIDTH-1:0] d_exp,
                      input logic [BW-1:0] b_exp);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = WIDTH'(val);
    in_sync  = sync;
    sent++;
    e.d = d_exp;
    e.b = b_exp;
    e.p = (sent >= PRIME_N);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sync  = 1'b0;
    end
  endtask

  task automatic run_stream(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      send(i, 1'b0, exp_data(i), BW'(i % BR));
      if (toggle) idle(1);
    end
    idle(4);
  endtask

  // Asynchronous reset pulse placed away from clock edges.
  task automatic do_reset(input bit check_async);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    if (check_async) begin
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_out_data", 32'(out_data), 32'd0);
      chk("async_primed", 32'(primed), 32'd0);
    end
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    sent  = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Test 1: reset state then first symbol on branch 0.
    do_reset(1'b0);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_branch", 32'(out_branch), 32'd0);
    chk("rst_primed", 32'(primed), 32'd0);
    send(32'h47, 1'b0, 8'h47, '0);
    idle(4);

    // Test 3: valid toggling 1,0,1,0 gives the same valid-output sequence.
    do_reset(1'b0);
    run_stream(300, 1'b1);

    // Test 6: reset mid-stream after symbol 1000 clears outputs at once.
    do_reset(1'b0);
    run_stream(1000, 1'b0);
    do_reset(1'b1);

    // Tests 2/4: continuous stream from a fresh start, through priming.
    run_stream(2300, 1'b0);
    chk("t2_idx1_data", 32'(cap_d[1]), 32'h00);
    chk("t2_idx1_branch", 32'(cap_b[1]), 32'd1);
    chk("t2_idx205_data", 32'(cap_d[205]), 32'h01);
    chk("t2_idx205_branch", 32'(cap_b[205]), 32'd1);
    chk("t2_idx13_data", 32'(cap_d[13]), 32'h00);
    chk("t2_idx2254_primed_pre", 32'(cap_idx), 32'd2300);
    chk("primed_sticky", 32'(primed), 32'd1);
    do_reset(1'b1);

    // Test 5: sync marker on index 5.
    for (int i = 0; i < 5; i++) send(i, 1'b0, exp_data(i), BW'(i % BR));
`ifdef SYNC_ALIGN_EN
    send(5, 1'b1, 8'h05, BW'(0));
    send(6, 1'b0, 8'h00, BW'(1));
`else
    send(5, 1'b1, 8'h00, BW'(5));
    send(6, 1'b0, 8'h00, BW'(6));
`endif
    idle(4);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
